// File: rtl/uart_bridge_pkg.sv
// Shared constants for the UART bus bridge: register map, STATUS bit positions
// and the TX launch state encoding.
package uart_bridge_pkg;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_TX_NOT_FULL  = 1;
    localparam int ST_RX_OVERRUN   = 2;
    localparam int ST_TX_OVERFLOW  = 3;
    localparam int ST_TX_IDLE      = 4;
    localparam int ST_RX_IRQ_EN    = 5;
    localparam int ST_TX_IRQ_EN    = 6;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head; pop of an empty FIFO is ignored and
// push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// Byte-wide bus front end for a UART: TX/RX FIFOs, STATUS/CTRL register, level irq
// and a launch FSM handshaking with the serial engine via tx_start/tx_busy.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       addr,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       irq,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_ready,
    input  logic [7:0] rx_data
);

    tx_state_e  state_q, state_d;
    logic       wait_cnt_q, wait_cnt_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       irq_q, irq_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_overflow_q, tx_overflow_d;
    logic       rx_irq_en_q, rx_irq_en_d;
    logic       tx_irq_en_q, tx_irq_en_d;

    logic       data_wr, ctrl_wr, data_rd, status_rd;
    logic       tx_full, tx_empty, tx_pop;
    logic       rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic       tx_idle;
    logic [7:0] status;

    assign data_wr   = wr_en && (addr == ADDR_DATA);
    assign ctrl_wr   = wr_en && (addr == ADDR_CTRL);
    assign data_rd   = rd_en && (addr == ADDR_DATA);
    assign status_rd = rd_en && (addr == ADDR_CTRL);
    assign tx_idle   = (state_q == S_IDLE) && tx_empty;

    // TX push is refused outright when full, even if the launch FSM pops that cycle.
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr && !tx_full),
        .pop   (tx_pop),
        .wdata (wr_data),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_ready),
        .pop   (data_rd),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        status                  = '0;
        status[ST_RX_NOT_EMPTY] = !rx_empty;
        status[ST_TX_NOT_FULL]  = !tx_full;
        status[ST_RX_OVERRUN]   = rx_overrun_q;
        status[ST_TX_OVERFLOW]  = tx_overflow_q;
        status[ST_TX_IDLE]      = tx_idle;
        status[ST_RX_IRQ_EN]    = rx_irq_en_q;
        status[ST_TX_IRQ_EN]    = tx_irq_en_q;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = (addr == ADDR_DATA) ? (rx_empty ? 8'h00 : rx_head) : status;
        end
        // A new error event in the same cycle as the STATUS read survives the clear.
        rx_overrun_d  = (rx_overrun_q && !status_rd) || (rx_ready && rx_full && !data_rd);
        tx_overflow_d = (tx_overflow_q && !status_rd) || (data_wr && tx_full);
        rx_irq_en_d   = ctrl_wr ? wr_data[0] : rx_irq_en_q;
        tx_irq_en_d   = ctrl_wr ? wr_data[1] : tx_irq_en_q;
        irq_d         = (rx_irq_en_q && !rx_empty) || (tx_irq_en_q && tx_idle);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    state_d    = S_LAUNCH;
                    tx_start_d = 1'b1;
                    tx_data_d  = tx_head;
                end
            end
            S_LAUNCH: begin
                tx_pop     = 1'b1;
                state_d    = S_WAIT_BUSY;
                wait_cnt_d = 1'b0;
            end
            S_WAIT_BUSY: begin
                // Engines that never raise busy release the FSM after two cycles.
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (wait_cnt_q) begin
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            rd_data_q     <= 8'h00;
            irq_q         <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_overflow_q <= 1'b0;
            rx_irq_en_q   <= 1'b0;
            tx_irq_en_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            rd_data_q     <= rd_data_d;
            irq_q         <= irq_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_overflow_q <= tx_overflow_d;
            rx_irq_en_q   <= rx_irq_en_d;
            tx_irq_en_q   <= tx_irq_en_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign irq      = irq_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: queue-based reference model, a modelled serial engine,
// directed scenarios with literal expectations and a randomized soak.
module tb_uart_bus_bridge;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, addr, wr_en, rd_en, rx_ready, tx_busy;
    logic [7:0] wr_data, rx_data, rd_data, tx_data;
    logic       irq, tx_start;

    always #5 clk = ~clk;

    uart_bus_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .irq      (irq),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .rx_ready (rx_ready),
        .rx_data  (rx_data)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state
    byte unsigned txq[$];
    byte unsigned rxq[$];
    byte unsigned txlog[$];
    bit          m_ovf, m_orun, m_rx_en, m_tx_en;
    int          quiet;
    bit          valid = 1'b0;
    logic [7:0]  rd_exp, rd_mask;
    bit          irq_exp, irq_known;
    bit          ts_s = 1'b0;

    // Serial engine model
    int eng_mode = 0;   // 0: busy for busy_len cycles, 1: busy forced high, 2: never busy
    int busy_len = 10;

    initial forever begin
        int  tidle, rx_pre, tx_pre;
        bit  rx_ne, popped, set_ovf, set_orun, status_rd;
        @(posedge clk);
        if (rst) begin
            txq.delete(); rxq.delete();
            m_ovf = 0; m_orun = 0; m_rx_en = 0; m_tx_en = 0;
            quiet = 8; rd_exp = 8'h00; rd_mask = 8'hFF;
            irq_exp = 0; irq_known = 1; valid = 1;
        end else if (valid) begin
            rx_pre = rxq.size();
            tx_pre = txq.size();
            rx_ne  = (rx_pre > 0);
            // tx_idle is only certain when the queue holds data or the engine has been quiet long enough
            tidle  = (tx_pre > 0) ? 0 : ((quiet >= 3) ? 1 : -1);
            if (m_rx_en && rx_ne) begin
                irq_exp = 1; irq_known = 1;
            end else if (!m_tx_en) begin
                irq_exp = 0; irq_known = 1;
            end else if (tidle >= 0) begin
                irq_exp = (tidle == 1); irq_known = 1;
            end else begin
                irq_known = 0;
            end
            popped = 0;
            status_rd = rd_en && addr;
            if (rd_en && !addr) begin
                rd_mask = 8'hFF;
                if (rx_ne) begin
                    rd_exp = rxq.pop_front();
                    popped = 1;
                end else begin
                    rd_exp = 8'h00;
                end
            end else if (status_rd) begin
                rd_exp  = {1'b0, m_tx_en, m_rx_en, (tidle == 1), m_ovf, m_orun, (tx_pre < DEPTH), rx_ne};
                rd_mask = (tidle < 0) ? 8'hEF : 8'hFF;
            end
            set_ovf = wr_en && !addr && (tx_pre == DEPTH);
            if (ts_s && txq.size() > 0) void'(txq.pop_front());
            if (wr_en && !addr && !set_ovf) txq.push_back(wr_data);
            set_orun = rx_ready && (rx_pre == DEPTH) && !popped;
            if (rx_ready && !set_orun) rxq.push_back(rx_data);
            m_ovf  = (m_ovf && !status_rd) || set_ovf;
            m_orun = (m_orun && !status_rd) || set_orun;
            if (wr_en && addr) begin
                m_rx_en = wr_data[0];
                m_tx_en = wr_data[1];
            end
            if (tx_busy || ts_s) quiet = 0;
            else if (quiet < 100) quiet++;
        end
    end

    // Compare process plus engine model, both on the falling edge
    initial begin
        int busy_cnt, stall;
        bit start_prev;
        busy_cnt = 0; stall = 0; start_prev = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (valid) begin
                chk("rd_data", int'(rd_data & rd_mask), int'(rd_exp & rd_mask));
                if (irq_known) chk("irq", int'(irq), int'(irq_exp));
                if (tx_start) begin
                    chk("tx_start_has_data", int'(txq.size() > 0), 1);
                    if (txq.size() > 0) chk("tx_data", int'(tx_data), int'(txq[0]));
                    chk("tx_start_vs_busy", int'(tx_busy), 0);
                    txlog.push_back(tx_data);
                end
                if (eng_mode != 1 && txq.size() > 0 && !tx_busy && !tx_start) stall++;
                else stall = 0;
                if (stall == 8) begin
                    checks++; failures++;
                    $display("FAIL tx_launch_stall: idle cycles=%0d, allowed<=7", stall);
                    stall = 0;
                end
            end
            ts_s = tx_start;
            if (eng_mode == 1) begin
                tx_busy = 1'b1;
            end else begin
                if (start_prev && eng_mode == 0) busy_cnt = busy_len;
                tx_busy = (busy_cnt > 0);
                if (busy_cnt > 0) busy_cnt--;
            end
            start_prev = tx_start;
        end
    end

    task automatic step(bit w, bit r, bit a, logic [7:0] d, bit rr, logic [7:0] rd);
        wr_en = w; rd_en = r; addr = a; wr_data = d; rx_ready = rr; rx_data = rd;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    initial begin
        int n0, n1, k;
        rst = 1'b1;
        wr_en = 0; rd_en = 0; addr = 0; wr_data = 0; rx_ready = 0; rx_data = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_irq", int'(irq), 0);
        chk("reset_tx_start", int'(tx_start), 0);
        chk("reset_tx_data", int'(tx_data), 0);
        step(0, 1, 1, 8'h00, 0, 8'h00);
        chk("reset_status", int'(rd_data), 'h12);

        // Two bytes through a 10-cycle engine
        eng_mode = 0; busy_len = 10;
        txlog.delete();
        step(1, 0, 0, 8'h41, 0, 8'h00);
        step(1, 0, 0, 8'h42, 0, 8'h00);
        idle(40);
        chk("tx_pulse_count", txlog.size(), 2);
        if (txlog.size() == 2) begin
            chk("tx_first_byte", int'(txlog[0]), 'h41);
            chk("tx_second_byte", int'(txlog[1]), 'h42);
        end

        // TX overflow with engine stuck busy
        eng_mode = 1;
        idle(2);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h10 + i), 0, 8'h00);
        step(0, 1, 1, 8'h00, 0, 8'h00);
        chk("status_tx_overflow_set", int'(rd_data[3]), 1);
        chk("status_tx_full", int'(rd_data[1]), 0);
        step(0, 1, 1, 8'h00, 0, 8'h00);
        chk("status_tx_overflow_clr", int'(rd_data[3]), 0);
        eng_mode = 0;
        idle(80);
        chk("tx_drain_count", txlog.size(), 6);
        if (txlog.size() == 6) chk("tx_drain_last", int'(txlog[5]), 'h13);

        // RX read order and empty read
        step(0, 0, 0, 8'h00, 1, 8'h55);
        step(0, 0, 0, 8'h00, 1, 8'hAA);
        step(0, 1, 0, 8'h00, 0, 8'h00);
        chk("rx_read_1", int'(rd_data), 'h55);
        step(0, 1, 0, 8'h00, 0, 8'h00);
        chk("rx_read_2", int'(rd_data), 'hAA);
        step(0, 1, 0, 8'h00, 0, 8'h00);
        chk("rx_read_empty", int'(rd_data), 0);

        // RX full with simultaneous pop, then overrun
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 8'h00, 1, 8'(i));
        step(0, 1, 0, 8'h00, 1, 8'h05);
        chk("rx_full_pop_push", int'(rd_data), 1);
        step(0, 1, 1, 8'h00, 0, 8'h00);
        chk("rx_no_overrun", int'(rd_data[2]), 0);
        chk("rx_not_empty", int'(rd_data[0]), 1);
        step(0, 0, 0, 8'h00, 1, 8'h06);
        step(0, 1, 1, 8'h00, 0, 8'h00);
        chk("status_overrun", int'(rd_data), 'h17);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00, 0, 8'h00);
            chk("rx_drain", int'(rd_data), 2 + i);
        end
        step(0, 1, 0, 8'h00, 0, 8'h00);
        chk("rx_drain_empty", int'(rd_data), 0);

        // Interrupt enables
        step(1, 0, 1, 8'h03, 0, 8'h00);
        idle(2);
        chk("irq_tx_idle", int'(irq), 1);
        step(0, 0, 0, 8'h00, 1, 8'h77);
        idle(2);
        chk("irq_rx_and_tx", int'(irq), 1);
        step(0, 1, 0, 8'h00, 0, 8'h00);
        chk("irq_rx_byte", int'(rd_data), 'h77);
        idle(2);
        chk("irq_after_drain", int'(irq), 1);
        step(1, 0, 1, 8'h01, 0, 8'h00);
        idle(2);
        chk("irq_rx_only_empty", int'(irq), 0);
        step(0, 0, 0, 8'h00, 1, 8'h88);
        idle(2);
        chk("irq_rx_arrival", int'(irq), 1);
        step(0, 1, 0, 8'h00, 0, 8'h00);
        step(1, 0, 1, 8'h00, 0, 8'h00);
        idle(2);
        chk("irq_disabled", int'(irq), 0);

        // Reset during WAIT_DONE with bytes still queued
        eng_mode = 0; busy_len = 20;
        n0 = txlog.size();
        step(1, 0, 0, 8'hA1, 0, 8'h00);
        step(1, 0, 0, 8'hA2, 0, 8'h00);
        step(1, 0, 0, 8'hA3, 0, 8'h00);
        k = 0;
        while (txlog.size() == n0 && k < 20) begin
            idle(1);
            k++;
        end
        chk("midtx_launch_seen", int'(txlog.size() > n0), 1);
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        step(0, 1, 1, 8'h00, 0, 8'h00);
        chk("midtx_reset_status", int'(rd_data), 'h12);
        n1 = txlog.size();
        idle(40);
        chk("midtx_no_relaunch", txlog.size(), n1);

        // Randomized soak
        for (int c = 0; c < 3000; c++) begin
            int op;
            bit rr;
            if (c % 100 == 0) begin
                op = $urandom_range(0, 8);
                eng_mode = (op < 6) ? 0 : ((op < 7) ? 1 : 2);
                busy_len = $urandom_range(1, 12);
            end
            rst = ($urandom_range(0, 499) == 0);
            rr = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 15);
            case (op)
                0, 1, 2, 3, 4: step(1, 0, 0, 8'($urandom), rr, 8'($urandom));
                5, 6, 7, 8:    step(0, 1, 0, 8'h00, rr, 8'($urandom));
                9, 10:         step(0, 1, 1, 8'h00, rr, 8'($urandom));
                11:            step(1, 0, 1, 8'($urandom_range(0, 3)), rr, 8'($urandom));
                12:            step(1, 1, 0, 8'($urandom), rr, 8'($urandom));
                13:            step(1, 1, 1, 8'($urandom_range(0, 3)), rr, 8'($urandom));
                default:       step(0, 0, 0, 8'h00, rr, 8'($urandom));
            endcase
        end
        rst = 1'b0;
        eng_mode = 0;
        idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the entries per direction; it SHALL be a power of 2 and at least 2.
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 addr  input  1  register select: 0 = DATA, 1 = STATUS/CTRL.
REQ-005 wr_en  input  1  bus write strobe, one cycle per access.
REQ-006 rd_en  input  1  bus read strobe, one cycle per access.
REQ-007 wr_data  input  8  bus write data.
REQ-008 rd_data  output  8  bus read data, registered.
REQ-009 irq  output  1  level interrupt request.
REQ-010 tx_start  output  1  one-cycle launch pulse to the serial transmit engine.
REQ-011 tx_data  output  8  byte to transmit; valid in the tx_start cycle.
REQ-012 tx_busy  input  1  transmit engine busy; rises the cycle after tx_start.
REQ-013 rx_ready  input  1  one-cycle pulse: the receive engine holds a valid byte.
REQ-014 rx_data  input  8  received byte; valid only while rx_ready is high.

Function
REQ-015 A DATA write SHALL push wr_data into the TX FIFO; if the TX FIFO is full, the byte SHALL be dropped and the sticky bit tx_overflow SHALL be set.
REQ-016 An rx_ready pulse SHALL push rx_data into the RX FIFO; if the RX FIFO is full and not popped in the same cycle, the byte SHALL be dropped and the sticky bit rx_overrun SHALL be set.
REQ-017 A DATA read SHALL load the RX FIFO head into rd_data on the next edge (latency 1) and pop it; reading an empty FIFO SHALL return 0x00 with no state change.
REQ-018 A STATUS read SHALL return, 1 cycle later: bit0 rx_not_empty, bit1 tx_not_full, bit2 rx_overrun, bit3 tx_overflow, bit4 tx_idle, bit5 rx_irq_en, bit6 tx_irq_en, bit7 0.
REQ-019 A STATUS read SHALL clear rx_overrun and tx_overflow; a set in the same cycle SHALL win over the clear.
REQ-020 A CTRL write SHALL load rx_irq_en = wr_data[0] and tx_irq_en = wr_data[1].
REQ-021 rd_data SHALL hold its value when rd_en is low; wr_en and rd_en high together SHALL perform both accesses.
REQ-022 irq SHALL equal (rx_irq_en AND rx_not_empty) OR (tx_irq_en AND tx_idle), registered.
REQ-023 The TX launch FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-024 In IDLE, if the TX FIFO is non-empty and tx_busy is low, the FSM SHALL go to LAUNCH.
REQ-025 In LAUNCH, the FSM SHALL assert tx_start for exactly 1 cycle, drive tx_data with the FIFO head, pop the FIFO, and go to WAIT_BUSY.
REQ-026 In WAIT_BUSY, the FSM SHALL go to WAIT_DONE when tx_busy is high, or return to IDLE after 2 cycles without busy.
REQ-027 In WAIT_DONE, the FSM SHALL go to IDLE when tx_busy is low.
REQ-028 tx_idle SHALL be 1 only when the FSM is in IDLE and the TX FIFO is empty.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; occupancy counts SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-030 A simultaneous push and pop SHALL leave the count unchanged, including when the FIFO is full; a push into an empty FIFO SHALL NOT be readable in the same cycle.

Reset
REQ-031 On rst, the block SHALL set: FIFOs empty, pointers 0, FSM IDLE, rd_data 0x00, tx_start 0, tx_data 0x00, irq 0, sticky bits 0, irq enables 0.
REQ-032 An rst asserted mid-transmission SHALL discard FIFO contents and return the FSM to IDLE; bytes already handed to the engine are not tracked.

Structure
REQ-033 The shared package uart_bridge_pkg SHALL hold the register address constants, STATUS bit indices and the FSM state encoding.
REQ-034 The block SHALL instantiate sub-module sync_fifo (parameters WIDTH, DEPTH; full/empty outputs) twice, once for TX and once for RX.

Verification
REQ-035 Write DATA 0x41, 0x42 with tx_busy modelled at 10 cycles -> two tx_start pulses carrying 0x41 then 0x42, no overlap with busy.
REQ-036 With tx_busy held high, 5 writes at depth 4 -> 4 bytes queued, tx_overflow=1; a STATUS read returns bit3=1; the next STATUS read returns bit3=0.
REQ-037 rx_ready with 0x55 then 0xAA, then 3 DATA reads -> rd_data 0x55, 0xAA, 0x00.
REQ-038 Fill the RX FIFO, then rx_ready together with a DATA read -> no overrun, count stays 4; rx_ready alone when full -> rx_overrun=1.
REQ-039 Write CTRL 0x03 -> irq=1 (TX idle); push one RX byte, then drain it -> irq stays 1; write CTRL 0x01 -> irq=0 until an RX byte arrives.
REQ-040 Assert rst during WAIT_DONE with 2 bytes queued -> after reset STATUS reads 0x12 and no further tx_start occurs.
